ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_tx_deb.sv | 38 +++
 rtl/ps2_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encodings and frame constants
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    // Host-driven bits per frame after the start bit: 8 data, parity, stop
    localparam int HOST_BITS         = 10;
    localparam int RTS_CYCLES        = 2;
    localparam int DEB_STABLE_CYCLES = 4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_deb.sv
// rtl/ps2_tx_deb.sv - synchronizing debouncer for the PS/2 clock line
module deb #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // dout follows the synchronized line only after it has held a new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            dout <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbclk,
    input  logic       in,
    output logic       kbclk_oe,
    output logic       kbdata_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       PAR_IDX  = 4'(HOST_BITS - 2);

    ps2_state_e       state, state_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             ack_q, ack_d;
    logic [3:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             clk_oe_d, dat_oe_d, done_d, err_d;
    logic             kbclk_deb, kbclk_prev, in_s1, in_sync, fe;

    deb #(.STABLE_CYCLES(DEB_STABLE_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (kbclk),
        .dout  (kbclk_deb)
    );

    assign fe = kbclk_prev & ~kbclk_deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            ack_q      <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            kbclk_prev <= 1'b0;
            in_s1      <= 1'b0;
            in_sync    <= 1'b0;
            kbclk_oe   <= 1'b0;
            kbdata_oe  <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ack_q      <= ack_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            kbclk_prev <= kbclk_deb;
            in_s1      <= in;
            in_sync    <= in_s1;
            kbclk_oe   <= clk_oe_d;
            kbdata_oe  <= dat_oe_d;
            tx_ready   <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            done       <= done_d;
            err        <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        data_d   = data_q;
        par_d    = par_q;
        ack_d    = ack_q;
        idx_d    = idx;
        cnt_d    = cnt;
        clk_oe_d = kbclk_oe;
        dat_oe_d = kbdata_oe;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    ack_d    = 1'b0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RTS: begin
                if (cnt == RTS_LAST) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (fe) begin
                    if (!idx[3]) begin
                        dat_oe_d = ~data_q[idx[2:0]];
                    end else if (idx == PAR_IDX) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                    idx_d = idx + 4'd1;
                end
            end
            ACK: begin
                if (fe) begin
                    if (!in_sync) begin
                        ack_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (ack_q && kbclk_deb && in_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Device-paced states abort if the device goes quiet; a completion in the same cycle wins
        if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
            cnt_d = fe ? '0 : cnt + 1'b1;
            if (!fe && cnt == TO_LAST && state_d != IDLE) begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                err_d    = 1'b1;
                state_d  = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;
    localparam int INH = 20;
    localparam int TO  = 300;
    localparam int RTSC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbclk, in_line;
    logic       kbclk_oe, kbdata_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err;

    // Open-drain wired lines: either side may pull low
    assign kbclk   = ~(kbclk_oe | dev_clk_low);
    assign in_line = ~(kbdata_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kbclk     (kbclk),
        .in        (in_line),
        .kbclk_oe  (kbclk_oe),
        .kbdata_oe (kbdata_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         acc_n = 0;
    int         acc_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         hi_cnt = 0;
    int         last_chg = 0;
    int         to_gap = -1;
    logic [7:0] acc_data = 8'h00;
    logic       acc_valid = 1'b0;
    logic       prev_doe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2) == 0;
        return {1'b1, par, d};
    endfunction

    // Event log: acceptances, pulses, clock-hold length, kbdata_oe change times
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            acc_valid <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (err) begin
                err_cnt <= err_cnt + 1;
                to_gap  <= cyc - last_chg;
            end
            if (done || err) acc_valid <= 1'b0;
            if (kbdata_oe != prev_doe && !err) last_chg <= cyc;
            prev_doe <= kbdata_oe;
            if (tx_valid && tx_ready) begin
                acc_n     <= acc_n + 1;
                acc_cyc   <= cyc + 1;
                acc_data  <= tx_data;
                acc_valid <= 1'b1;
                hi_cnt    <= 0;
                to_gap    <= -1;
            end else if (kbclk_oe) begin
                hi_cnt <= hi_cnt + 1;
            end
        end
    end

    // Per-cycle comparison against the host-side timeline of a frame
    always @(negedge clk) begin
        int k;
        if (rst_n) begin
            check("done_err_excl", done & err, 1'b0);
            check("ready_vs_busy", tx_ready, !busy);
            if (acc_valid && !(done || err)) begin
                k = cyc - acc_cyc;
                check("busy_in_frame", busy, 1'b1);
                if (k < INH) begin
                    check("inhibit_clk", kbclk_oe, 1'b1);
                    check("inhibit_dat", kbdata_oe, 1'b0);
                end else if (k < INH + RTSC) begin
                    check("rts_clk", kbclk_oe, 1'b1);
                    check("rts_dat", kbdata_oe, 1'b1);
                end else begin
                    check("released_clk", kbclk_oe, 1'b0);
                    if (k == INH + RTSC) check("start_bit", kbdata_oe, 1'b1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit hold);
        int n0;
        int i;
        n0 = acc_n;
        i = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (acc_n == n0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("accepted", acc_n, n0 + 1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic device(input int nedge, input bit ack, output logic [10:0] s);
        int i;
        s = '1;
        i = 0;
        while (!(busy && !kbclk_oe && kbdata_oe) && i < INH + 50) begin
            @(negedge clk);
            i++;
        end
        check("rts_seen", i < INH + 50, 1'b1);
        repeat ($urandom_range(20, 30)) @(negedge clk);
        for (int e = 0; e < nedge; e++) begin
            if (e == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat ($urandom_range(12, 30)) @(negedge clk);
            s[e] = in_line;
            dev_clk_low = 1'b0;
            repeat ($urandom_range(12, 30)) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, output logic [10:0] s);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d, 1'b0);
        device(11, ack, s);
        wait_idle();
        check("frame", s[9:0], model_frame(d));
        check("done_count", done_cnt - d0, ack);
        check("err_count", err_cnt - e0, !ack);
        check("clk_hold_len", hi_cnt, INH + RTSC);
    endtask

    initial begin
        logic [10:0] s;
        logic [7:0]  d, d2;
        int          d0, e0, a0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_clk_oe", kbclk_oe, 1'b0);
        check("rst_dat_oe", kbdata_oe, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_ready", tx_ready, 1'b1);

        xfer(8'hED, 1'b1, s);
        check("ed_bits", s[9:0], 10'h3ED);
        check("ed_ack_line", s[10], 1'b0);
        xfer(8'hF4, 1'b1, s);
        check("f4_bits", s[9:0], 10'h2F4);

        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom);
            xfer(d, 1'b1, s);
        end

        d = 8'($urandom);
        xfer(d, 1'b0, s);
        check("nack_clk_oe", kbclk_oe, 1'b0);
        check("nack_dat_oe", kbdata_oe, 1'b0);
        check("nack_ready", tx_ready, 1'b1);

        // Bits 2 and 3 differ so the last device edge is visible on kbdata_oe
        d = 8'($urandom);
        d[3] = ~d[2];
        d0 = done_cnt;
        e0 = err_cnt;
        send(d, 1'b0);
        device(4, 1'b0, s);
        wait_idle();
        check("to_gap", to_gap, TO);
        check("to_err", err_cnt - e0, 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_clk_oe", kbclk_oe, 1'b0);
        check("to_dat_oe", kbdata_oe, 1'b0);

        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED, 1'b0);
        device(5, 1'b0, s);
        check("pre_reset_dat_oe", kbdata_oe, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_clk_oe", kbclk_oe, 1'b0);
        check("reset_dat_oe", kbdata_oe, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("reset_no_done", done_cnt - d0, 0);
        check("reset_no_err", err_cnt - e0, 0);
        check("reset_ready", tx_ready, 1'b1);
        xfer(8'hED, 1'b1, s);
        check("post_reset_ed", s[9:0], 10'h3ED);

        d  = 8'($urandom);
        d2 = ~d;
        d0 = done_cnt;
        a0 = acc_n;
        send(d, 1'b1);
        tx_data = d2;
        device(11, 1'b1, s);
        wait_idle();
        tx_valid = 1'b0;
        check("hold_first_frame", s[9:0], model_frame(d));
        check("hold_one_done", done_cnt - d0, 1);
        check("hold_second_acc", acc_n - a0, 2);
        check("hold_second_data", acc_data, d2);
        device(11, 1'b1, s);
        wait_idle();
        check("hold_second_frame", s[9:0], model_frame(d2));
        check("hold_two_done", done_cnt - d0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
